// File: rtl/mcs4_shift_reg.sv
// mcs4_shift_reg: parametrised i4003-style serial-in/parallel-out shifter with
// cp edge qualification, parallel load, shift counter and full flag.
module mcs4_shift_reg #(
    parameter int SYSCLK_TCY     = 20,
    parameter int WIDTH          = 10,
    parameter int LATCH_DELAY_NS = 250,
    parameter int MSB_FIRST      = 1
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic                         cp,
    input  logic                         serial_in,
    input  logic                         enable,
    input  logic                         load,
    input  logic [WIDTH-1:0]             parallel_in,
    output logic [WIDTH-1:0]             parallel_out,
    output logic                         serial_out,
    output logic [$clog2(WIDTH+1)-1:0]   shift_count,
    output logic                         full
);
    localparam int N  = (LATCH_DELAY_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int DW = N > 0 ? $clog2(N + 1) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shifter, shifted;
    logic [DW-1:0]    dcnt;
    logic             cp_delayed, cp_edge, tail;

    // An edge is accepted on the (N+1)th consecutive sample that differs from
    // the last accepted level; a sample matching it restarts qualification.
    always_comb begin
        cp_edge      = (cp != cp_delayed) && (dcnt == DW'(N));
        shifted      = MSB_FIRST != 0 ? {shifter[WIDTH-2:0], serial_in} : {serial_in, shifter[WIDTH-1:1]};
        tail         = MSB_FIRST != 0 ? shifter[WIDTH-1] : shifter[0];
        parallel_out = enable ? shifter : '0;
        full         = shift_count == CW'(WIDTH);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            shifter     <= '0;
            serial_out  <= 1'b0;
            dcnt        <= '0;
            shift_count <= '0;
            cp_delayed  <= cp;
        end else begin
            dcnt <= (cp == cp_delayed || cp_edge) ? '0 : dcnt + 1'b1;
            if (cp_edge)
                cp_delayed <= cp;
            if (cp_edge && !cp)
                serial_out <= tail;
            // Load wins over a coincident rise; the rise is still consumed above.
            if (load) begin
                shifter     <= parallel_in;
                shift_count <= '0;
            end else if (cp_edge && cp) begin
                shifter <= shifted;
                if (!full)
                    shift_count <= shift_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mcs4_shift_reg.sv
// tb_mcs4_shift_reg: randomized and directed checks of two mcs4_shift_reg
// instances (MSB-first W=10, LSB-first W=4) against a behavioural model.
module tb_mcs4_shift_reg;
    localparam int N = 13;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1, cp = 1'b0, serial_in = 1'b0, enable = 1'b1, load = 1'b0;
    logic [9:0]  parallel_in = '0;
    logic [9:0]  pa;
    logic [3:0]  pb;
    logic        soa, sob, fa, fb;
    logic [3:0]  ca;
    logic [2:0]  cb;

    int n_cmp = 0, n_bad = 0;
    bit started = 0;

    always #10 sysclk = ~sysclk;

    mcs4_shift_reg #(.WIDTH(10), .MSB_FIRST(1)) dut_a (
        .sysclk(sysclk), .rst(rst), .cp(cp), .serial_in(serial_in), .enable(enable),
        .load(load), .parallel_in(parallel_in), .parallel_out(pa), .serial_out(soa),
        .shift_count(ca), .full(fa));

    mcs4_shift_reg #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
        .sysclk(sysclk), .rst(rst), .cp(cp), .serial_in(serial_in), .enable(enable),
        .load(load), .parallel_in(parallel_in[3:0]), .parallel_out(pb), .serial_out(sob),
        .shift_count(cb), .full(fb));

    // Behavioural model: shifter contents held as plain integers.
    int w[2] = '{10, 4};
    int val[2], cnt[2], run[2];
    bit acc[2], so[2];

    always @(posedge sysclk) begin
        for (int d = 0; d < 2; d++) begin
            int mask;
            bit edge_ok, tl;
            mask = (1 << w[d]) - 1;
            if (rst) begin
                val[d] = 0; so[d] = 0; cnt[d] = 0; run[d] = 0; acc[d] = cp;
            end else begin
                edge_ok = 0;
                if (cp != acc[d]) begin
                    run[d]++;
                    if (run[d] == N + 1) begin edge_ok = 1; run[d] = 0; end
                end else run[d] = 0;
                tl = d == 0 ? val[d][w[d]-1] : val[d][0];
                if (edge_ok && !cp) so[d] = tl;
                if (load) begin
                    val[d] = int'(parallel_in) & mask; cnt[d] = 0;
                end else if (edge_ok && cp) begin
                    val[d] = d == 0 ? ((val[d] << 1) | int'(serial_in)) & mask
                                    : (val[d] >> 1) | (int'(serial_in) << (w[d] - 1));
                    cnt[d] = cnt[d] < w[d] ? cnt[d] + 1 : w[d];
                end
                if (edge_ok) acc[d] = cp;
            end
        end
        if (rst) started = 1;
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge sysclk) begin
        if (started) begin
            cmp("a_parallel_out", int'(pa),  enable ? val[0] : 0);
            cmp("a_serial_out",   int'(soa), int'(so[0]));
            cmp("a_shift_count",  int'(ca),  cnt[0]);
            cmp("a_full",         int'(fa),  int'(cnt[0] == 10));
            cmp("b_parallel_out", int'(pb),  enable ? val[1] : 0);
            cmp("b_serial_out",   int'(sob), int'(so[1]));
            cmp("b_shift_count",  int'(cb),  cnt[1]);
            cmp("b_full",         int'(fb),  int'(cnt[1] == 4));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge sysclk); #1; end
    endtask

    task automatic pulse_hl(input bit si);
        serial_in = si; cp = 1'b1; tick(20); cp = 1'b0; tick(20);
    endtask

    initial begin
        // Reset with cp high, then hold cp high: no edge must appear.
        rst = 1'b1; cp = 1'b1; tick(3); rst = 1'b0;
        tick(50);
        cmp("lit_rst_pa", int'(pa), 0);
        cmp("lit_rst_so", int'(soa), 0);
        cmp("lit_rst_cnt", int'(ca), 0);
        cmp("lit_rst_full", int'(fa), 0);
        // Drop cp (qualified fall, tail 0), then a rise: shift on the 14th edge.
        cp = 1'b0; tick(20);
        serial_in = 1'b1; cp = 1'b1; tick(13);
        cmp("lit_pre14_pa", int'(pa), 0);
        tick(1);
        cmp("lit_at14_pa", int'(pa), 10'h001);
        tick(6); cp = 1'b0; tick(20);
        cmp("lit_pulse_so", int'(soa), 0);
        // Short glitch must be ignored; a 14-cycle pulse shifts.
        cp = 1'b1; tick(5); cp = 1'b0; tick(20);
        cmp("lit_glitch_pa", int'(pa), 10'h001);
        cp = 1'b1; tick(14); cp = 1'b0; tick(20);
        cmp("lit_after_glitch_pa", int'(pa), 10'h003);
        // Load 0x200 with cp accepted high, then fall (tail=1) and rise.
        cp = 1'b1; tick(20);
        parallel_in = 10'h200; load = 1'b1; tick(1); load = 1'b0;
        serial_in = 1'b0; cp = 1'b0; tick(20);
        cmp("lit_load_so", int'(soa), 1);
        cp = 1'b1; tick(20);
        cmp("lit_load_pa", int'(pa), 10'h000);
        cmp("lit_load_cnt", int'(ca), 1);
        // Saturation: load 0, then 12 rises of serial_in=1.
        parallel_in = 10'h000; load = 1'b1; tick(1); load = 1'b0;
        serial_in = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cp = 1'b0; tick(20); cp = 1'b1; tick(20);
            if (i == 9) cmp("lit_full9", int'(fa), 0);
            if (i == 10) cmp("lit_full10", int'(fa), 1);
        end
        cmp("lit_sat_pa", int'(pa), 10'h3FF);
        cmp("lit_sat_cnt", int'(ca), 10);
        enable = 1'b0; tick(3);
        cmp("lit_en0_pa", int'(pa), 0);
        enable = 1'b1; tick(1);
        cmp("lit_en1_pa", int'(pa), 10'h3FF);
        // LSB-first instance: shift in 1,0,0,0.
        rst = 1'b1; cp = 1'b0; tick(2); rst = 1'b0; tick(2);
        pulse_hl(1); pulse_hl(0); pulse_hl(0); pulse_hl(0);
        cmp("lit_b_pa", int'(pb), 4'b0001);
        cmp("lit_b_full", int'(fb), 1);
        // Load on the same edge as a qualified rise: load wins, edge consumed.
        cp = 1'b1; tick(13);
        parallel_in = 10'h005; load = 1'b1; tick(1); load = 1'b0;
        cmp("lit_b_loadrise_pa", int'(pb), 4'h5);
        cmp("lit_b_loadrise_cnt", int'(cb), 0);
        tick(20);
        cmp("lit_b_consumed_pa", int'(pb), 4'h5);
        cmp("lit_a_consumed_pa", int'(pa), 10'h005);
        // Randomized phase checked by the model every cycle.
        for (int k = 0; k < 300; k++) begin
            int len;
            cp = ~cp;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : $urandom_range(13, 30);
            for (int j = 0; j < len; j++) begin
                serial_in   = 1'($urandom);
                enable      = $urandom_range(0, 7) != 0;
                load        = $urandom_range(0, 60) == 0;
                parallel_in = 10'($urandom);
                rst         = $urandom_range(0, 700) == 0;
                tick(1);
            end
        end
        rst = 1'b0; load = 1'b0; tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
